// File: rtl/mult_bitmanip_ctrl.sv
// Front-end for the EX-stage multiplier: MUL ops pass through, BEXT/BDEP run on a bit-serial engine.
// Latency: MUL 0 cycles; BEXT/BDEP issue 64/BITS_PER_CYCLE+1 cycles after accept.
// Backpressure: ready_o drops for the whole engine run and its issue cycle.
package mult_bitmanip_pkg;
    typedef enum logic [3:0] {
        ADD, SUB, MUL, MULH, MULHU, MULHSU, MULW, BEXT, BDEP, DIV
    } fu_op;
endpackage

module mult_bitmanip_ctrl
    import mult_bitmanip_pkg::*;
#(
    parameter int TRANS_ID_BITS  = 3,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  fu_op                     operator_i,
    input  logic [63:0]              operand_a_i,
    input  logic [63:0]              operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     ready_o,
    output logic                     mul_valid_o,
    output fu_op                     mul_operator_o,
    output logic [63:0]              mul_operand_a_o,
    output logic [63:0]              mul_operand_b_o,
    output logic [TRANS_ID_BITS-1:0] mul_trans_id_o,
    output logic                     multi_cycle_o,
    output logic [63:0]              multi_cycle_result_o
);
    localparam int NCHUNK = 64 / BITS_PER_CYCLE;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, ISSUE} state_e;

    state_e                   state_q, state_d;
    fu_op                     op_q;
    logic [63:0]              a_q, mask_q, res_q, res_d;
    logic [TRANS_ID_BITS-1:0] id_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [6:0]               ptr_q, ptr_d;

    logic       is_mul, is_bm, accept_bm, last_chunk;
    logic [6:0] eng_p;
    logic [5:0] eng_base, eng_k;

    assign is_mul     = operator_i inside {MUL, MULH, MULHU, MULHSU, MULW};
    assign is_bm      = operator_i inside {BEXT, BDEP};
    assign accept_bm  = (state_q == IDLE) && valid_i && is_bm && !flush_i;
    assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

    // One chunk of mask bits; the pointer ripples through the chunk in ascending bit order.
    always_comb begin
        res_d    = res_q;
        eng_p    = ptr_q;
        eng_base = 6'(int'(cnt_q) * BITS_PER_CYCLE);
        eng_k    = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            eng_k = eng_base + 6'(j);
            if (mask_q[eng_k]) begin
                if (op_q == BEXT) begin
                    res_d[eng_p[5:0]] = a_q[eng_k];
                end else begin
                    res_d[eng_k] = a_q[eng_p[5:0]];
                end
                eng_p = eng_p + 7'd1;
            end
        end
        ptr_d = eng_p;
        cnt_d = last_chunk ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_bm) state_d = RUN;
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (last_chunk) begin
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A flush freezes the engine state; the result register is only cleared by the next accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q   <= BEXT;
            a_q    <= '0;
            mask_q <= '0;
            id_q   <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
        end else if (accept_bm) begin
            op_q   <= operator_i;
            a_q    <= operand_a_i;
            mask_q <= operand_b_i;
            id_q   <= trans_id_i;
            res_q  <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
        end else if (state_q == RUN && !flush_i) begin
            res_q <= res_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ready_o         = (state_q == IDLE);
        mul_valid_o     = 1'b0;
        multi_cycle_o   = 1'b0;
        mul_operator_o  = operator_i;
        mul_operand_a_o = operand_a_i;
        mul_operand_b_o = operand_b_i;
        mul_trans_id_o  = trans_id_i;
        case (state_q)
            // Pass-through is combinational, so it must be gated by reset explicitly.
            IDLE: mul_valid_o = rst_ni && valid_i && is_mul && !flush_i;
            ISSUE: begin
                mul_valid_o     = !flush_i;
                multi_cycle_o   = !flush_i;
                mul_operator_o  = op_q;
                mul_trans_id_o  = id_q;
                mul_operand_a_o = '0;
                mul_operand_b_o = '0;
            end
            default: ;
        endcase
    end

    assign multi_cycle_result_o = res_q;

endmodule

// File: tb/tb_mult_bitmanip_ctrl.sv
`timescale 1ns/1ps
module tb_mult_bitmanip_ctrl;
    import mult_bitmanip_pkg::*;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        flush [ND];
    logic        vld   [ND];
    fu_op        op    [ND];
    logic [63:0] opa   [ND];
    logic [63:0] opb   [ND];
    logic [2:0]  tid   [ND];
    logic        rdy   [ND];
    logic        mvld  [ND];
    logic        mc    [ND];
    fu_op        mop   [ND];
    logic [63:0] ma    [ND];
    logic [63:0] mb    [ND];
    logic [63:0] mres  [ND];
    logic [2:0]  mid   [ND];

    int n_chk = 0;
    int n_err = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int B = (g == 0) ? 8 : (g == 1) ? 1 : 64;
        mult_bitmanip_ctrl #(.TRANS_ID_BITS(3), .BITS_PER_CYCLE(B)) u_dut (
            .clk_i               (clk),
            .rst_ni              (rst_n),
            .flush_i             (flush[g]),
            .valid_i             (vld[g]),
            .operator_i          (op[g]),
            .operand_a_i         (opa[g]),
            .operand_b_i         (opb[g]),
            .trans_id_i          (tid[g]),
            .ready_o             (rdy[g]),
            .mul_valid_o         (mvld[g]),
            .mul_operator_o      (mop[g]),
            .mul_operand_a_o     (ma[g]),
            .mul_operand_b_o     (mb[g]),
            .mul_trans_id_o      (mid[g]),
            .multi_cycle_o       (mc[g]),
            .multi_cycle_result_o(mres[g])
        );
    end

    // Hand-computed BEXT/BDEP vectors
    fu_op        vop [6] = '{BEXT, BDEP, BDEP, BEXT, BDEP, BEXT};
    logic [63:0] va  [6] = '{64'h00A5, 64'h3, 64'hFFFF, 64'h0123_4567_89AB_CDEF,
                             64'h00A5, 64'h8000_0000_0000_0000};
    logic [63:0] vb  [6] = '{64'h00F0, 64'h8000_0000_0000_0001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hF0F0, 64'h8000_0000_0000_0001};
    logic [2:0]  vid [6] = '{3'd4, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
    logic [63:0] vexp[6] = '{64'hA, 64'h8000_0000_0000_0001, 64'h0, 64'h0123_4567_89AB_CDEF,
                             64'hA050, 64'h2};

    function automatic int bpc_of(input int idx);
        return (idx == 0) ? 8 : (idx == 1) ? 1 : 64;
    endfunction

    function automatic string tg(input int idx, input string s);
        return $sformatf("%s[bpc%0d]", s, bpc_of(idx));
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs just after the rising edge, return at the falling edge for sampling.
    task automatic drive(input int idx, input logic v, input fu_op o, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] id, input logic f);
        @(posedge clk); #1;
        vld[idx] = v; op[idx] = o; opa[idx] = a; opb[idx] = b; tid[idx] = id; flush[idx] = f;
        @(negedge clk);
    endtask

    task automatic idle(input int idx);
        drive(idx, 1'b0, ADD, 64'd0, 64'd0, 3'd0, 1'b0);
    endtask

    task automatic accept(input int idx, input fu_op o, input logic [63:0] a,
                          input logic [63:0] b, input logic [2:0] id);
        drive(idx, 1'b1, o, a, b, id, 1'b0);
        chk(tg(idx, "acc_vld"), mvld[idx], 0);
        chk(tg(idx, "acc_rdy"), rdy[idx], 1);
    endtask

    task automatic wait_issue(input int idx, input fu_op o, input logic [2:0] id,
                              input logic [63:0] exp, input int exp_lat);
        int          icyc = -1;
        int          rdy_bad = 0;
        logic        r_mc = 1'b0;
        logic [2:0]  r_id = 3'd0;
        fu_op        r_op = ADD;
        logic [63:0] r_a = 64'd0, r_b = 64'd0, r_res = 64'd0;
        for (int c = 1; c <= 80 && icyc < 0; c++) begin
            idle(idx);
            if (rdy[idx]) rdy_bad++;
            if (mvld[idx]) begin
                icyc = c; r_mc = mc[idx]; r_id = mid[idx]; r_op = mop[idx];
                r_a = ma[idx]; r_b = mb[idx]; r_res = mres[idx];
            end
        end
        chk(tg(idx, "issue_cyc"), 64'(icyc), 64'(exp_lat));
        chk(tg(idx, "busy_rdy"), 64'(rdy_bad), 64'd0);
        chk(tg(idx, "issue_mc"), r_mc, 1);
        chk(tg(idx, "issue_id"), r_id, id);
        chk(tg(idx, "issue_op"), r_op, o);
        chk(tg(idx, "issue_a0"), r_a, 0);
        chk(tg(idx, "issue_b0"), r_b, 0);
        chk(tg(idx, "issue_res"), r_res, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        for (int i = 0; i < ND; i++) begin
            flush[i] = 1'b0; vld[i] = 1'b0; op[i] = ADD;
            opa[i] = 64'd0; opb[i] = 64'd0; tid[i] = 3'd0;
        end
        vld[0] = 1'b1; op[0] = MUL;
        #23;
        for (int i = 0; i < ND; i++) begin
            chk(tg(i, "rst_rdy"), rdy[i], 1);
            chk(tg(i, "rst_vld"), mvld[i], 0);
            chk(tg(i, "rst_mc"), mc[i], 0);
            chk(tg(i, "rst_res"), mres[i], 0);
        end
        vld[0] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Pass-through and ignored operators
        drive(0, 1'b1, MUL, 64'd3, 64'd5, 3'd2, 1'b0);
        chk("pt_vld", mvld[0], 1);
        chk("pt_op", mop[0], MUL);
        chk("pt_a", ma[0], 3);
        chk("pt_b", mb[0], 5);
        chk("pt_id", mid[0], 2);
        chk("pt_rdy", rdy[0], 1);
        chk("pt_mc", mc[0], 0);
        idle(0);
        drive(2, 1'b1, MULHU, 64'hDEAD_BEEF_0000_0001, 64'h1234, 3'd7, 1'b0);
        chk("pt2_vld", mvld[2], 1);
        chk("pt2_op", mop[2], MULHU);
        chk("pt2_a", ma[2], 64'hDEAD_BEEF_0000_0001);
        chk("pt2_id", mid[2], 7);
        idle(2);
        drive(1, 1'b1, ADD, 64'd1, 64'd2, 3'd3, 1'b0);
        chk("ign_vld", mvld[1], 0);
        idle(1);
        chk("ign_rdy", rdy[1], 1);

        // BEXT/BDEP vectors on every engine width, with result hold check after ISSUE
        for (int d = 0; d < ND; d++) begin
            for (int v = 0; v < 6; v++) begin
                accept(d, vop[v], va[v], vb[v], vid[v]);
                wait_issue(d, vop[v], vid[v], vexp[v], 64 / bpc_of(d) + 1);
                idle(d);
                chk(tg(d, "hold_res"), mres[d], vexp[v]);
                chk(tg(d, "post_rdy"), rdy[d], 1);
                chk(tg(d, "post_vld"), mvld[d], 0);
            end
        end

        // BEXT accepted in the cycle after ISSUE
        accept(0, BEXT, 64'hA5, 64'hF0, 3'd4);
        wait_issue(0, BEXT, 3'd4, 64'hA, 9);
        drive(0, 1'b1, BEXT, 64'hFF, 64'hF0, 3'd5, 1'b0);
        chk("b2b_hold", mres[0], 64'hA);
        chk("b2b_rdy", rdy[0], 1);
        idle(0);
        chk("b2b_clr", mres[0], 0);
        wait_issue(0, BEXT, 3'd5, 64'hF, 8);

        // Flush in RUN cycle 4, then a MUL passes through
        accept(0, BEXT, 64'hA5, 64'hF0, 3'd1);
        cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            idle(0);
            if (mvld[0]) cnt++;
        end
        drive(0, 1'b0, ADD, 64'd0, 64'd0, 3'd0, 1'b1);
        if (mvld[0]) cnt++;
        drive(0, 1'b1, MUL, 64'd7, 64'd9, 3'd3, 1'b0);
        chk("fl_rdy", rdy[0], 1);
        chk("fl_mul_vld", mvld[0], 1);
        chk("fl_mul_a", ma[0], 7);
        chk("fl_mul_id", mid[0], 3);
        for (int c = 0; c < 12; c++) begin
            idle(0);
            if (mvld[0]) cnt++;
        end
        chk("fl_no_issue", 64'(cnt), 64'd0);

        // Flush during ISSUE on the single-chunk engine
        accept(2, BDEP, 64'h3, 64'h11, 3'd6);
        idle(2);
        drive(2, 1'b0, ADD, 64'd0, 64'd0, 3'd0, 1'b1);
        chk("fli_vld", mvld[2], 0);
        chk("fli_mc", mc[2], 0);
        idle(2);
        chk("fli_rdy", rdy[2], 1);
        chk("fli_vld2", mvld[2], 0);

        // valid with flush in IDLE is not accepted
        drive(0, 1'b1, BEXT, 64'hA5, 64'hF0, 3'd2, 1'b1);
        chk("flid_vld", mvld[0], 0);
        idle(0);
        chk("flid_rdy", rdy[0], 1);
        drive(0, 1'b1, MUL, 64'd1, 64'd1, 3'd1, 1'b1);
        chk("flid_mul", mvld[0], 0);
        idle(0);

        // Reset pulse during RUN
        accept(0, BEXT, 64'hA5, 64'hF0, 3'd4);
        idle(0);
        idle(0);
        @(posedge clk); #1 rst_n = 1'b0;
        #2;
        chk("mrst_res", mres[0], 0);
        chk("mrst_rdy", rdy[0], 1);
        chk("mrst_vld", mvld[0], 0);
        chk("mrst_mc", mc[0], 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            idle(0);
            if (mvld[0]) cnt++;
        end
        chk("mrst_no_issue", 64'(cnt), 64'd0);
        chk("mrst_rdy2", rdy[0], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
